// File: rtl/rvbridge_pkt_sched.sv
// Packet scheduler: emits a 10-beat control packet and a type-0 video header around each raw frame.
// Optional macro RVB_SIZE_CHECK_EN adds a pixel-count checker with sticky output err_size.
module rvbridge_pkt_sched #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [15:0]           cfg_width,
  input  logic [15:0]           cfg_height,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  err_overrun,
  output logic                  err_drop,
`ifdef RVB_SIZE_CHECK_EN
  output logic                  err_size,
`endif
  input  logic                  err_clr
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CTRL    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_VIDEO   = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic                    in_frame_r;
  logic [3:0]              beat_r;
  logic [15:0]             width_r, height_r;
  logic                    skip_r;
  logic [DATA_WIDTH-1:0]   pix_data_r;
  logic                    pix_valid_r;
  logic                    err_overrun_r, err_drop_r;
  logic [DATA_WIDTH-1:0]   out_data_s;
  logic                    out_valid_s, out_sop_s, out_eop_s;
  logic                    ctrl_start_s, drop_s;

  // Control packet nibble k: type 0xF, width and height MSB-first, then progressive 0x0.
  function automatic logic [3:0] ctrl_nibble(input logic [3:0] k, input logic [15:0] w,
                                             input logic [15:0] h);
    case (k)
      4'd0:    ctrl_nibble = 4'hF;
      4'd1:    ctrl_nibble = w[15:12];
      4'd2:    ctrl_nibble = w[11:8];
      4'd3:    ctrl_nibble = w[7:4];
      4'd4:    ctrl_nibble = w[3:0];
      4'd5:    ctrl_nibble = h[15:12];
      4'd6:    ctrl_nibble = h[11:8];
      4'd7:    ctrl_nibble = h[7:4];
      4'd8:    ctrl_nibble = h[3:0];
      default: ctrl_nibble = 4'h0;
    endcase
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state and ST output decode; header and eop beats follow the input in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    out_data_s  = '0;
    out_valid_s = 1'b0;
    out_sop_s   = 1'b0;
    out_eop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && !in_frame_r && !in_sop) state_nxt_s = ST_CTRL;
        else if (enable && in_frame_r)        state_nxt_s = ST_DISCARD;
        else                                  state_nxt_s = ST_IDLE;
      end
      ST_CTRL: begin
        out_valid_s = 1'b1;
        out_data_s  = DATA_WIDTH'(ctrl_nibble(beat_r, width_r, height_r));
        out_sop_s   = (beat_r == 4'd0);
        out_eop_s   = (beat_r == 4'd9);
        if (out_ready && (beat_r == 4'd9)) begin
          if (skip_r || in_sop) state_nxt_s = ST_DISCARD;
          else if (enable)      state_nxt_s = ST_ARMED;
          else                  state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CTRL;
        end
      end
      ST_ARMED: begin
        if (in_sop) begin
          out_valid_s = 1'b1;
          out_sop_s   = 1'b1;
          state_nxt_s = ST_VIDEO;
        end else if (!enable) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_VIDEO: begin
        out_valid_s = pix_valid_r;
        out_data_s  = pix_valid_r ? pix_data_r : '0;
        out_eop_s   = pix_valid_r && in_eop;
        if (in_eop) state_nxt_s = enable ? ST_CTRL : ST_IDLE;
        else        state_nxt_s = ST_VIDEO;
      end
      ST_DISCARD: begin
        if ((in_eop || !in_frame_r) && !in_sop) state_nxt_s = enable ? ST_CTRL : ST_IDLE;
        else                                    state_nxt_s = ST_DISCARD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign ctrl_start_s = (state_nxt_s == ST_CTRL) && (state_r != ST_CTRL);
  assign drop_s       = out_valid_s && !out_ready &&
                        ((state_r == ST_ARMED) || (state_r == ST_VIDEO));

  // Frame tracking, control-beat counter, configuration latch and pixel delay stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_r  <= 1'b0;
      beat_r      <= 4'd0;
      width_r     <= 16'd0;
      height_r    <= 16'd0;
      skip_r      <= 1'b0;
      pix_data_r  <= '0;
      pix_valid_r <= 1'b0;
    end else begin
      if (in_eop)      in_frame_r <= 1'b0;
      else if (in_sop) in_frame_r <= 1'b1;
      if (state_r == ST_CTRL) begin
        if (out_ready) beat_r <= (beat_r == 4'd9) ? 4'd0 : beat_r + 4'd1;
      end else begin
        beat_r <= 4'd0;
      end
      if (ctrl_start_s) begin
        width_r  <= cfg_width;
        height_r <= cfg_height;
        skip_r   <= 1'b0;
      end else if ((state_r == ST_CTRL) && in_sop) begin
        skip_r   <= 1'b1;
      end
      pix_data_r  <= in_data;
      pix_valid_r <= in_valid;
    end
  end

  // Sticky error flags; a new error event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun_r <= 1'b0;
      err_drop_r    <= 1'b0;
    end else begin
      if ((state_r == ST_CTRL) && in_sop) err_overrun_r <= 1'b1;
      else if (err_clr)                   err_overrun_r <= 1'b0;
      if (drop_s)       err_drop_r <= 1'b1;
      else if (err_clr) err_drop_r <= 1'b0;
    end
  end

`ifdef RVB_SIZE_CHECK_EN
  logic [31:0] prod_r, vcnt_r;
  logic        err_size_r;

  // Pixel counter compared against the latched width*height at the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r     <= 32'd0;
      vcnt_r     <= 32'd0;
      err_size_r <= 1'b0;
    end else begin
      if (ctrl_start_s) prod_r <= cfg_width * cfg_height;
      if ((state_r == ST_ARMED) && in_sop)            vcnt_r <= 32'd0;
      else if ((state_r == ST_VIDEO) && pix_valid_r) vcnt_r <= vcnt_r + 32'd1;
      if ((state_r == ST_VIDEO) && pix_valid_r && in_eop && ((vcnt_r + 32'd1) != prod_r))
        err_size_r <= 1'b1;
      else if (err_clr)
        err_size_r <= 1'b0;
    end
  end

  assign err_size = err_size_r;
`endif

  assign out_data    = out_data_s;
  assign out_valid   = out_valid_s;
  assign out_sop     = out_sop_s;
  assign out_eop     = out_eop_s;
  assign busy        = (state_r != ST_IDLE);
  assign err_overrun = err_overrun_r;
  assign err_drop    = err_drop_r;

endmodule

// File: tb/tb_rvbridge_pkt_sched.sv
// Scoreboard bench for rvbridge_pkt_sched: expected ST beats are queued as stimulus is driven.
module tb_rvbridge_pkt_sched;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, enable, in_valid, in_sop, in_eop, out_ready, err_clr;
  logic [15:0]   cfg_width, cfg_height;
  logic [DW-1:0] in_data, out_data;
  logic          out_valid, out_sop, out_eop, busy, err_overrun, err_drop;
`ifdef RVB_SIZE_CHECK_EN
  logic          err_size;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t sb[$];
  int    test_cnt = 0;
  int    fail_cnt = 0;

  always #5 clk = ~clk;

  rvbridge_pkt_sched #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready), .busy(busy), .err_overrun(err_overrun), .err_drop(err_drop),
`ifdef RVB_SIZE_CHECK_EN
    .err_size(err_size),
`endif
    .err_clr(err_clr)
  );

  // Pops one expected beat for every beat the sink accepts.
  task automatic monitor();
    beat_t exp_b;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        test_cnt++;
        if (sb.size() == 0) begin
          fail_cnt++;
          $display("FAIL beat_unexpected: got data=%h sop=%b eop=%b, required no beat",
                   out_data, out_sop, out_eop);
        end else begin
          exp_b = sb.pop_front();
          if ({out_data, out_sop, out_eop} !== exp_b) begin
            fail_cnt++;
            $display("FAIL beat @%0t: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                     $time, out_data, out_sop, out_eop, exp_b.d, exp_b.sop, exp_b.eop);
          end
        end
      end
    end
  endtask

  task automatic push_ctrl(input logic [15:0] w, input logic [15:0] h);
    logic [3:0] nib[10];
    beat_t b;
    nib = '{4'hF, w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], 4'h0};
    for (int k = 0; k < 10; k++) begin
      b.d   = {4'h0, nib[k]};
      b.sop = (k == 0);
      b.eop = (k == 9);
      sb.push_back(b);
    end
  endtask

  task automatic push_frame(input int n, input logic [7:0] base, input int skip_idx);
    beat_t b;
    b.d = 8'h00; b.sop = 1'b1; b.eop = 1'b0;
    sb.push_back(b);
    for (int i = 0; i < n; i++) begin
      if (i != skip_idx) begin
        b.d   = base + 8'(i);
        b.sop = 1'b0;
        b.eop = (i == n - 1);
        sb.push_back(b);
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Pixels on cycles 0..n-1, in_eop on cycle n; out_ready low on the output cycle of drop_idx.
  task automatic drive_frame(input int n, input logic [7:0] base, input int drop_idx,
                             input logic en_sop, input logic en_rest);
    for (int c = 0; c <= n; c++) begin
      in_sop    = (c == 0);
      in_valid  = (c < n);
      in_eop    = (c == n);
      in_data   = (c < n) ? base + 8'(c) : 8'h00;
      enable    = (c == 0) ? en_sop : en_rest;
      out_ready = !((drop_idx >= 0) && (c == drop_idx + 1));
      @(posedge clk); #1;
    end
    in_sop = 1'b0; in_valid = 1'b0; in_eop = 1'b0; in_data = 8'h00; out_ready = 1'b1;
  endtask

  task automatic check_drained(input string name);
    test_cnt++;
    if (sb.size() !== 0) begin
      fail_cnt++;
      $display("FAIL %s_drained: %0d beats still pending, required 0", name, sb.size());
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    test_cnt += 6;
    if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    if ({out_sop, out_eop} !== 2'b00) begin fail_cnt++; $display("FAIL rst_sop_eop: got %b required 00", {out_sop, out_eop}); end
    if (out_data !== 8'h00) begin fail_cnt++; $display("FAIL rst_data: got %h required 00", out_data); end
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (err_overrun !== 1'b0) begin fail_cnt++; $display("FAIL rst_overrun: got %b required 0", err_overrun); end
    if (err_drop !== 1'b0) begin fail_cnt++; $display("FAIL rst_drop: got %b required 0", err_drop); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    cfg_width = 16'd4; cfg_height = 16'd2; enable = 1'b1;
    push_ctrl(16'd4, 16'd2);
    idle(20);
    push_frame(8, 8'h10, -1);
    drive_frame(8, 8'h10, -1, 1'b0, 1'b0);
    idle(3);
    check_drained("basic");
    test_cnt += 2;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL basic_idle: busy got %b required 0", busy); end
    if ({err_overrun, err_drop} !== 2'b00) begin fail_cnt++; $display("FAIL basic_errs: got %b required 00", {err_overrun, err_drop}); end
  endtask

  task automatic test_ready_toggle();
    logic [7:0] held_d;
    logic       held_v;
    cfg_width = 16'hA5C3; cfg_height = 16'h1234; enable = 1'b1;
    push_ctrl(16'hA5C3, 16'h1234);
    for (int i = 0; i < 26; i++) begin
      out_ready = (i % 2 == 1);
      held_d = out_data;
      held_v = out_valid && !out_ready;
      @(posedge clk); #1;
      if (held_v) begin
        test_cnt++;
        if (out_data !== held_d) begin
          fail_cnt++;
          $display("FAIL ctrl_hold: got %h required %h", out_data, held_d);
        end
      end
    end
    out_ready = 1'b1;
    idle(2);
    push_frame(4, 8'h40, -1);
    drive_frame(4, 8'h40, -1, 1'b0, 1'b0);
    idle(3);
    check_drained("ready_toggle");
  endtask

  task automatic test_overrun();
    cfg_width = 16'd4; cfg_height = 16'd2; enable = 1'b1;
    push_ctrl(16'd4, 16'd2);
    idle(12);
    push_frame(8, 8'h20, -1);
    drive_frame(8, 8'h20, -1, 1'b1, 1'b1);
    push_ctrl(16'd4, 16'd2);
    idle(4);
    drive_frame(8, 8'h60, -1, 1'b1, 1'b1);
    push_ctrl(16'd4, 16'd2);
    idle(12);
    push_frame(8, 8'h80, -1);
    drive_frame(8, 8'h80, -1, 1'b0, 1'b0);
    idle(3);
    check_drained("overrun");
    test_cnt += 2;
    if (err_overrun !== 1'b1) begin fail_cnt++; $display("FAIL overrun_flag: got %b required 1", err_overrun); end
    if (err_drop !== 1'b0) begin fail_cnt++; $display("FAIL overrun_nodrop: got %b required 0", err_drop); end
    pulse_clr();
    test_cnt++;
    if (err_overrun !== 1'b0) begin fail_cnt++; $display("FAIL overrun_clr: got %b required 0", err_overrun); end
  endtask

  task automatic test_drop();
    cfg_width = 16'd4; cfg_height = 16'd2; enable = 1'b1;
    push_ctrl(16'd4, 16'd2);
    idle(12);
    push_frame(8, 8'hA0, 3);
    drive_frame(8, 8'hA0, 3, 1'b0, 1'b0);
    idle(3);
    check_drained("drop");
    test_cnt += 2;
    if (err_drop !== 1'b1) begin fail_cnt++; $display("FAIL drop_flag: got %b required 1", err_drop); end
    if (err_overrun !== 1'b0) begin fail_cnt++; $display("FAIL drop_nooverrun: got %b required 0", err_overrun); end
    pulse_clr();
    test_cnt++;
    if (err_drop !== 1'b0) begin fail_cnt++; $display("FAIL drop_clr: got %b required 0", err_drop); end
  endtask

  task automatic test_discard();
    cfg_width = 16'h0123; cfg_height = 16'h0000; enable = 1'b0;
    idle(2);
    push_ctrl(16'h0123, 16'h0000);
    drive_frame(6, 8'hC0, -1, 1'b0, 1'b1);
    test_cnt++;
    if (busy !== 1'b1) begin fail_cnt++; $display("FAIL discard_to_ctrl: busy got %b required 1", busy); end
    idle(12);
    test_cnt += 2;
    if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL armed_valid: got %b required 0", out_valid); end
    if (busy !== 1'b1) begin fail_cnt++; $display("FAIL armed_busy: got %b required 1", busy); end
    enable = 1'b0;
    idle(2);
    test_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL armed_to_idle: busy got %b required 0", busy); end
    check_drained("discard");
  endtask

`ifdef RVB_SIZE_CHECK_EN
  task automatic test_size();
    cfg_width = 16'd4; cfg_height = 16'd2; enable = 1'b1;
    push_ctrl(16'd4, 16'd2);
    idle(12);
    push_frame(7, 8'h30, -1);
    drive_frame(7, 8'h30, -1, 1'b1, 1'b1);
    push_ctrl(16'd4, 16'd2);
    test_cnt++;
    if (err_size !== 1'b1) begin fail_cnt++; $display("FAIL size_short: got %b required 1", err_size); end
    pulse_clr();
    idle(12);
    push_frame(8, 8'h50, -1);
    drive_frame(8, 8'h50, -1, 1'b0, 1'b0);
    idle(3);
    check_drained("size");
    test_cnt++;
    if (err_size !== 1'b0) begin fail_cnt++; $display("FAIL size_exact: got %b required 0", err_size); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_width = 16'd0; cfg_height = 16'd0;
    in_data = 8'h00; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;
    fork
      monitor();
    join_none
    #1;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_overrun();
    test_drop();
    test_discard();
`ifdef RVB_SIZE_CHECK_EN
    test_size();
`endif
    idle(2);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
